pat_serializer: RTL and testbench

PAT_SERIALIZER -- requirements
Module: pat_serializer

---
 rtl/pat_pkg.sv | 13 +
 rtl/pat_serializer_if.sv | 27 ++
 rtl/pat_fifo.sv | 51 +++++
 rtl/pat_serializer.sv | 110 +++++++++++
 tb/tb_pat_serializer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pat_pkg.sv
// Shared types and defaults for the pattern serializer.
// Imported by the FIFO, the serializer top and the bench.
package pat_pkg;

  localparam int DEF_DEPTH    = 4;
  localparam bit DEF_IDLE_BIT = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/pat_serializer_if.sv
// Byte-in / bit-out bundle of the pattern serializer.
// master drives bytes, slave is the serializer.
interface pat_serializer_if #(
  parameter int DEPTH = 4
);

  logic [7:0]             in_byte;
  logic                   in_valid;
  logic                   in_ready;
  logic                   data;
  logic                   bit_valid;
  logic                   byte_done;
  logic [$clog2(DEPTH):0] level;

  modport master (
    output in_byte, in_valid,
    input  in_ready, data, bit_valid,
    input  byte_done, level
  );

  modport slave (
    input  in_byte, in_valid,
    output in_ready, data, bit_valid,
    output byte_done, level
  );

endinterface

// File: rtl/pat_fifo.sv
// Byte FIFO feeding the serializer.
// Occupancy is registered; pointers wrap modulo DEPTH.
module pat_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [LW-1:0] level
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (level != LW'(DEPTH));
  assign do_pop  = pop && (level != '0);
  assign dout    = mem[rd_ptr];

  // storage write; blocked while reset so reset leaves no trace
  always_ff @(posedge clk) begin
    if (!reset && do_push)
      mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (do_pop && !do_push)
        level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/pat_serializer.sv
// Byte FIFO plus shift FSM producing a registered bit stream.
// Back-to-back bytes are sent with no gap bit between them.
module pat_serializer
  import pat_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic           clk,
  input  logic           reset,
  pat_serializer_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t        state;
  state_t        state_n;
  logic [2:0]    cnt;
  logic [2:0]    cnt_n;
  logic [7:0]    sh;
  logic [7:0]    sh_n;
  logic          data_q;
  logic          data_n;
  logic          bv_q;
  logic          bv_n;
  logic          bd_q;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic [LW-1:0] lvl;

  assign bus.in_ready  = (lvl != LW'(DEPTH));
  assign bus.level     = lvl;
  assign bus.data      = data_q;
  assign bus.bit_valid = bv_q;
  assign bus.byte_done = bd_q;
  assign push          = bus.in_valid && bus.in_ready;

  pat_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.in_byte),
    .pop   (pop),
    .dout  (head),
    .level (lvl)
  );

  // next state: shift current byte, chain next one, or idle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    data_n  = IDLE_BIT;
    bv_n    = 1'b0;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (lvl != '0) begin
          pop     = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != 3'd0) begin
          data_n = MSB_FIRST ? sh[7] : sh[0];
          sh_n   = MSB_FIRST ? {sh[6:0], 1'b0}
                             : {1'b0, sh[7:1]};
          bv_n   = 1'b1;
          cnt_n  = cnt - 3'd1;
        end else if (lvl != '0) begin
          pop = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      data_n = MSB_FIRST ? head[7] : head[0];
      sh_n   = MSB_FIRST ? {head[6:0], 1'b0}
                         : {1'b0, head[7:1]};
      bv_n   = 1'b1;
      cnt_n  = 3'd7;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      sh     <= 8'd0;
      data_q <= IDLE_BIT;
      bv_q   <= 1'b0;
      bd_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      data_q <= data_n;
      bv_q   <= bv_n;
      bd_q   <= bv_n && (cnt_n == 3'd0);
    end
  end

endmodule

// File: tb/tb_pat_serializer.sv
// Directed bench for pat_serializer.
// Two instances: MSB-first (a) and LSB-first (b).
module tb_pat_serializer;
  import pat_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pat_serializer_if #(.DEPTH(4)) ifa ();
  pat_serializer_if #(.DEPTH(4)) ifb ();

  pat_serializer #(
    .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );

  pat_serializer #(
    .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  logic rx_en = 1'b0;
  logic rx_q[$];
  int   lvl_max;
  bit   rdy_low;

  always begin
    @(posedge clk);
    #1;
    if (rx_en) begin
      if (ifa.bit_valid)
        rx_q.push_back(ifa.data);
      if (int'(ifa.level) > lvl_max)
        lvl_max = int'(ifa.level);
      if (!ifa.in_ready)
        rdy_low = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] got;
    ifa.in_byte  = 8'hA5;
    ifa.in_valid = 1'b1;
    ifb.in_byte  = 8'h5A;
    ifb.in_valid = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    got = {ifa.data, ifa.bit_valid,
           ifa.byte_done, ifa.in_ready};
    vectors++;
    if (got !== 4'b1001) begin
      miscompares++;
      $display("FAIL reset_out_a got %b want 1001", got);
    end
    vectors++;
    if (ifa.level !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_level_a got %0d want 0",
               ifa.level);
    end
    got = {ifb.data, ifb.bit_valid,
           ifb.byte_done, ifb.in_ready};
    vectors++;
    if (got !== 4'b1001) begin
      miscompares++;
      $display("FAIL reset_out_b got %b want 1001", got);
    end
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    reset = 1'b0;
    tick();
    vectors++;
    if (ifa.in_ready !== 1'b1 || ifa.level !== 3'd0) begin
      miscompares++;
      $display("FAIL post_reset got rdy=%b lvl=%0d want 1/0",
               ifa.in_ready, ifa.level);
    end
  endtask

  task automatic test_single;
    logic [7:0] seq;
    logic [2:0] got;
    logic [2:0] want;
    seq = 8'b0011_0111;
    ifa.in_byte  = 8'h37;
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    vectors++;
    if (ifa.bit_valid !== 1'b0 || ifa.level !== 3'd1) begin
      miscompares++;
      $display("FAIL single_lat got bv=%b lvl=%0d want 0/1",
               ifa.bit_valid, ifa.level);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      got  = {ifa.data, ifa.bit_valid, ifa.byte_done};
      want = {seq[7-i], 1'b1, (i == 7)};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL single_bit%0d got %b want %b",
                 i, got, want);
      end
    end
    tick();
    got = {ifa.data, ifa.bit_valid, ifa.byte_done};
    vectors++;
    if (got !== 3'b100) begin
      miscompares++;
      $display("FAIL single_tail got %b want 100", got);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq;
    logic [2:0] got;
    logic [2:0] want;
    seq = 8'b0011_0111;
    ifa.in_byte  = 8'h37;
    ifa.in_valid = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0)
        ifa.in_valid = 1'b0;
      got  = {ifa.data, ifa.bit_valid, ifa.byte_done};
      want = {seq[7-(i%8)], 1'b1, ((i % 8) == 7)};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL b2b_bit%0d got %b want %b",
                 i, got, want);
      end
    end
    tick();
    got = {ifa.data, ifa.bit_valid, ifa.byte_done};
    vectors++;
    if (got !== 3'b100 || ifa.level !== 3'd0) begin
      miscompares++;
      $display("FAIL b2b_tail got %b lvl=%0d want 100/0",
               got, ifa.level);
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] seq;
    logic [2:0] got;
    logic [2:0] want;
    seq = 8'b0011_0111;
    ifb.in_byte  = 8'hEC;
    ifb.in_valid = 1'b1;
    tick();
    ifb.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      got  = {ifb.data, ifb.bit_valid, ifb.byte_done};
      want = {seq[7-i], 1'b1, (i == 7)};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL lsb_bit%0d got %b want %b",
                 i, got, want);
      end
    end
    tick();
    got = {ifb.data, ifb.bit_valid, ifb.byte_done};
    vectors++;
    if (got !== 3'b100) begin
      miscompares++;
      $display("FAIL lsb_tail got %b want 100", got);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] bytes [6];
    logic [7:0] rb;
    bit         acc;
    int         guard;
    bytes = '{8'hA1, 8'h5C, 8'h3E, 8'hF0, 8'h96, 8'h0B};
    rx_q.delete();
    lvl_max = 0;
    rdy_low = 1'b0;
    rx_en   = 1'b1;
    for (int b = 0; b < 6; b++) begin
      ifa.in_byte  = bytes[b];
      ifa.in_valid = 1'b1;
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 50) begin
        acc = ifa.in_ready;
        tick();
        guard++;
      end
      if (!acc) begin
        miscompares++;
        $display("FAIL bp_accept%0d got stuck want accepted", b);
      end
    end
    ifa.in_valid = 1'b0;
    guard = 0;
    while (rx_q.size() < 48 && guard < 200) begin
      tick();
      guard++;
    end
    tick();
    rx_en = 1'b0;
    vectors++;
    if (rx_q.size() != 48) begin
      miscompares++;
      $display("FAIL bp_count got %0d want 48", rx_q.size());
    end
    vectors++;
    if (lvl_max != 4) begin
      miscompares++;
      $display("FAIL bp_peak got %0d want 4", lvl_max);
    end
    vectors++;
    if (!rdy_low) begin
      miscompares++;
      $display("FAIL bp_ready_low got 0 want 1");
    end
    for (int b = 0; b < 6; b++) begin
      rb = 8'h00;
      for (int i = 0; i < 8; i++)
        if (rx_q.size() > b*8+i)
          rb = {rb[6:0], rx_q[b*8+i]};
      vectors++;
      if (rb !== bytes[b]) begin
        miscompares++;
        $display("FAIL bp_byte%0d got %h want %h",
                 b, rb, bytes[b]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] got;
    bit         leak;
    ifa.in_valid = 1'b1;
    ifa.in_byte  = 8'h37;
    tick();
    ifa.in_byte  = 8'hAA;
    tick();
    ifa.in_byte  = 8'h55;
    tick();
    ifa.in_valid = 1'b0;
    tick();
    tick();
    got = {ifa.data, ifa.bit_valid, ifa.byte_done};
    vectors++;
    if (got !== 3'b110 || ifa.level !== 3'd2) begin
      miscompares++;
      $display("FAIL mid_bit4 got %b lvl=%0d want 110/2",
               got, ifa.level);
    end
    reset = 1'b1;
    ifa.in_valid = 1'b1;
    ifa.in_byte  = 8'hFF;
    tick();
    reset = 1'b0;
    ifa.in_valid = 1'b0;
    got = {ifa.data, ifa.bit_valid, ifa.byte_done};
    vectors++;
    if (got !== 3'b100 || ifa.level !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_reset got %b lvl=%0d want 100/0",
               got, ifa.level);
    end
    tick();
    vectors++;
    if (ifa.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_ready got %b want 1", ifa.in_ready);
    end
    leak = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ifa.bit_valid !== 1'b0 || ifa.data !== 1'b1)
        leak = 1'b1;
    end
    vectors++;
    if (leak) begin
      miscompares++;
      $display("FAIL mid_residual got payload want none");
    end
  endtask

  task automatic test_idle;
    logic [2:0] ga;
    logic [2:0] gb;
    for (int i = 0; i < 20; i++) begin
      tick();
      ga = {ifa.data, ifa.bit_valid, ifa.byte_done};
      gb = {ifb.data, ifb.bit_valid, ifb.byte_done};
      vectors++;
      if (ga !== 3'b100 || gb !== 3'b100) begin
        miscompares++;
        $display("FAIL idle%0d got a=%b b=%b want 100",
                 i, ga, gb);
      end
    end
  endtask

  initial begin
    ifa.in_byte  = 8'h00;
    ifa.in_valid = 1'b0;
    ifb.in_byte  = 8'h00;
    ifb.in_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_backpressure();
    test_reset_mid();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
